// File: rtl/freq_meter.sv
`timescale 1ns/1ps
// Reciprocal-free frequency meter: counts synchronized rising edges of sig_in
// over a fixed gate of GATE_CYC clk cycles and reports the count as freq.
module freq_meter #(
  parameter int GATE_CYC = 50000000,
  parameter int CNT_W    = 27
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             sig_in,
  input  logic             en,
  output logic [CNT_W-1:0] freq,
  output logic             freq_vld,
  output logic             ovf,
  output logic             busy
);

  localparam int              GW        = (GATE_CYC > 1) ? $clog2(GATE_CYC) : 1;
  localparam logic [GW-1:0]   GATE_LAST = GW'(GATE_CYC - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  typedef enum logic [1:0] {IDLE, GATE, DONE} state_t;

  state_t           r_state;
  logic             r_sync_p0;
  logic             r_sync_p1;
  logic             r_sig_p2;
  logic [GW-1:0]    r_gate_cnt;
  logic [CNT_W-1:0] r_edge_cnt;
  logic             r_ovf_flag;

  logic             w_strobe;
  logic             w_sat;
  logic             w_last;
  logic [CNT_W-1:0] w_edge_nxt;
  logic             w_ovf_nxt;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic inc);
    if (inc && (v != CNT_MAX)) return v + CNT_W'(1);
    return v;
  endfunction

  // p0/p1: metastability synchronizer, p2: delay flop for edge detection
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync_p0 <= 1'b0;
      r_sync_p1 <= 1'b0;
      r_sig_p2  <= 1'b0;
    end else begin
      r_sync_p0 <= sig_in;
      r_sync_p1 <= r_sync_p0;
      r_sig_p2  <= r_sync_p1;
    end
  end

  assign w_strobe   = r_sync_p1 & ~r_sig_p2;
  assign w_sat      = (r_edge_cnt == CNT_MAX);
  assign w_edge_nxt = sat_inc(r_edge_cnt, w_strobe);
  assign w_ovf_nxt  = r_ovf_flag | (w_strobe & w_sat);
  assign w_last     = (r_gate_cnt == GATE_LAST);

  // Result is loaded on the last gate cycle so freq_vld is high during DONE
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_gate_cnt <= '0;
      r_edge_cnt <= '0;
      r_ovf_flag <= 1'b0;
      freq       <= '0;
      freq_vld   <= 1'b0;
      ovf        <= 1'b0;
      busy       <= 1'b0;
    end else begin
      freq_vld <= 1'b0;
      case (r_state)
        IDLE: begin
          if (en) begin
            r_state    <= GATE;
            busy       <= 1'b1;
            r_gate_cnt <= '0;
            r_edge_cnt <= '0;
            r_ovf_flag <= 1'b0;
          end
        end
        GATE: begin
          if (!en) begin
            r_state <= IDLE;
            busy    <= 1'b0;
          end else begin
            r_gate_cnt <= r_gate_cnt + GW'(1);
            r_edge_cnt <= w_edge_nxt;
            r_ovf_flag <= w_ovf_nxt;
            if (w_last) begin
              r_state  <= DONE;
              busy     <= 1'b0;
              freq     <= w_edge_nxt;
              ovf      <= w_ovf_nxt;
              freq_vld <= 1'b1;
            end
          end
        end
        DONE: begin
          if (en) begin
            r_state    <= GATE;
            busy       <= 1'b1;
            r_gate_cnt <= '0;
            r_edge_cnt <= '0;
            r_ovf_flag <= 1'b0;
          end else begin
            r_state <= IDLE;
            busy    <= 1'b0;
          end
        end
        default: begin
          r_state <= IDLE;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_freq_meter.sv
`timescale 1ns/1ps
// Scoreboard bench for freq_meter: stimulus pushes expected results, a negedge
// monitor pops them whenever a DUT raises its valid pulse.
module tb_freq_meter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        sig_in;
  logic        en;
  logic        en4;
  logic [26:0] freq;
  logic        freq_vld, ovf, busy;
  logic [3:0]  freq4;
  logic        vld4, ovf4, busy4;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    int   f;
    logic o;
    int   tol;
  } exp_t;

  exp_t q[$];
  exp_t q4[$];
  exp_t e, e4;

  int   sig_per = 10;
  logic sig_lvl = 1'b0;
  int   ph      = 0;

  logic prev_vld  = 1'b0;
  logic prev_vld4 = 1'b0;

  always #5 clk = ~clk;

  freq_meter #(.GATE_CYC(1000), .CNT_W(27)) dut (
    .clk(clk), .rst_n(rst_n), .sig_in(sig_in), .en(en),
    .freq(freq), .freq_vld(freq_vld), .ovf(ovf), .busy(busy)
  );

  freq_meter #(.GATE_CYC(1000), .CNT_W(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .sig_in(sig_in), .en(en4),
    .freq(freq4), .freq_vld(vld4), .ovf(ovf4), .busy(busy4)
  );

  // Periodic stimulus: high for the first half of each period, or a constant level
  initial begin
    sig_in = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (sig_per == 0) begin
        sig_in = sig_lvl;
      end else begin
        sig_in = (ph < sig_per / 2);
        ph     = (ph + 1) % sig_per;
      end
    end
  end

  task automatic set_sig(input int p);
    sig_per = p;
    ph      = 0;
  endtask

  task automatic set_const(input logic l);
    sig_lvl = l;
    sig_per = 0;
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, req);
    end
  endtask

  // Counts posedges until the selected DUT raises its valid; checks latency when exp_lat > 0
  task automatic wait_vld(input string name, input bit sel4, input int exp_lat, input int budget);
    int n;
    bit seen;
    n    = 0;
    seen = 1'b0;
    while (n < budget && !seen) begin
      @(posedge clk);
      #1;
      n++;
      if (sel4 ? vld4 : freq_vld) seen = 1'b1;
    end
    if (!seen) begin
      checks++;
      failures++;
      $display("FAIL %s_timeout: no valid within %0d cycles, expected at %0d", name, budget, exp_lat);
    end else if (exp_lat > 0) begin
      chk(name, n, exp_lat);
    end
  endtask

  always @(negedge clk) begin
    if (freq_vld) begin
      checks++;
      if (prev_vld) begin
        failures++;
        $display("FAIL vld_consec: got two consecutive freq_vld cycles, expected single pulse");
      end
      if (q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL vld_unexpected: got freq_vld freq=%0d, expected no result", freq);
      end else begin
        e = q.pop_front();
        checks++;
        if (int'(freq) > e.f + e.tol || int'(freq) < e.f - e.tol) begin
          failures++;
          $display("FAIL freq: got %0d expected %0d (+/-%0d)", freq, e.f, e.tol);
        end
        checks++;
        if (ovf !== e.o) begin
          failures++;
          $display("FAIL ovf: got %0d expected %0d", ovf, e.o);
        end
      end
    end
    if (vld4) begin
      if (q4.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL vld4_unexpected: got vld freq=%0d, expected no result", freq4);
      end else begin
        e4 = q4.pop_front();
        checks++;
        if (int'(freq4) > e4.f + e4.tol || int'(freq4) < e4.f - e4.tol) begin
          failures++;
          $display("FAIL freq4: got %0d expected %0d", freq4, e4.f);
        end
        checks++;
        if (ovf4 !== e4.o) begin
          failures++;
          $display("FAIL ovf4: got %0d expected %0d", ovf4, e4.o);
        end
      end
    end
    prev_vld  = freq_vld;
    prev_vld4 = vld4;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got simulation still running, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0;
    en    = 1'b0;
    en4   = 1'b0;
    #2;
    chk("rst_freq", freq, 0);
    chk("rst_vld", freq_vld, 0);
    chk("rst_ovf", ovf, 0);
    chk("rst_busy", busy, 0);
    chk("rst_freq4", freq4, 0);
    step(3);
    rst_n = 1'b1;
    step(3);
    chk("idle_busy", busy, 0);

    // Continuous measurement of a 10-clk period
    set_sig(10);
    step(20);
    en = 1'b1;
    q.push_back('{100, 1'b0, 0});
    q.push_back('{100, 1'b0, 0});
    step(1);
    chk("gate_busy", busy, 1);
    wait_vld("s031_lat", 1'b0, 1000, 1100);
    chk("done_busy", busy, 0);
    step(1);
    chk("regate_busy", busy, 1);
    wait_vld("s031_period", 1'b0, 1000, 1100);

    // Abort at gate cycle 500, then rerun
    step(501);
    en = 1'b0;
    step(1);
    chk("abort_busy", busy, 0);
    step(1200);
    chk("abort_freq_hold", freq, 100);
    en = 1'b1;
    q.push_back('{100, 1'b0, 0});
    wait_vld("s033_rerun", 1'b0, 1001, 1100);
    en = 1'b0;
    step(3);
    chk("stop_busy", busy, 0);

    // Constant levels produce no edges
    set_const(1'b0);
    step(5);
    en = 1'b1;
    q.push_back('{0, 1'b0, 0});
    wait_vld("s032_low", 1'b0, 1001, 1100);
    en = 1'b0;
    set_const(1'b1);
    step(5);
    en = 1'b1;
    q.push_back('{0, 1'b0, 0});
    wait_vld("s032_high", 1'b0, 1001, 1100);
    en = 1'b0;
    step(2);

    // Maximum measurable rate
    set_sig(2);
    step(5);
    en = 1'b1;
    q.push_back('{500, 1'b0, 1});
    wait_vld("s035_fast", 1'b0, 1001, 1100);
    en = 1'b0;
    step(2);

    // Saturation on the narrow-counter instance, then a clean gate
    set_sig(4);
    step(5);
    en4 = 1'b1;
    q4.push_back('{15, 1'b1, 0});
    wait_vld("s034_sat", 1'b1, 1001, 1100);
    en4 = 1'b0;
    step(2);
    set_sig(100);
    step(5);
    en4 = 1'b1;
    q4.push_back('{10, 1'b0, 0});
    wait_vld("s034_clean", 1'b1, 1001, 1100);
    en4 = 1'b0;
    step(2);

    // Asynchronous reset mid-gate
    set_sig(10);
    step(5);
    en = 1'b1;
    step(300);
    rst_n = 1'b0;
    #1;
    chk("arst_freq", freq, 0);
    chk("arst_vld", freq_vld, 0);
    chk("arst_ovf", ovf, 0);
    chk("arst_busy", busy, 0);
    chk("arst_freq4", freq4, 0);
    step(3);
    rst_n = 1'b1;
    q.push_back('{100, 1'b0, 1});
    wait_vld("s036_lat", 1'b0, 1001, 1100);
    en = 1'b0;
    step(3);
    chk("queue_empty", q.size() + q4.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/freq_meter.md
FREQ_METER -- requirements
Module: freq_meter

Interface
REQ-001 The block SHALL have parameter GATE_CYC, default 50000000, gate length in clk cycles; 1 s at 50 MHz, so the result is in Hz.
REQ-002 The block SHALL have parameter CNT_W, default 27, width of the edge counter and of freq.
REQ-003 The block SHALL have port clk, input, 1, system clock, 50 MHz nominal.
REQ-004 The block SHALL have port rst_n, input, 1, reset, asynchronous, active-low.
REQ-005 The block SHALL have port sig_in, input, 1, signal under measurement, asynchronous to clk.
REQ-006 The block SHALL have port en, input, 1, level-sensitive measurement enable.
REQ-007 The block SHALL have port freq, output, CNT_W, rising-edge count of the last completed gate, held between updates.
REQ-008 The block SHALL have port freq_vld, output, 1, one-clk pulse when freq is updated.
REQ-009 The block SHALL have port ovf, output, 1, set if the last completed gate saturated the counter; updated together with freq.
REQ-010 The block SHALL have port busy, output, 1, high while in state GATE.

Function
REQ-011 sig_in SHALL pass through a 2-flop synchronizer and then a third delay flop.
REQ-012 The rising-edge strobe SHALL be sync2 & ~sig_d; latency from a sig_in rising edge to the strobe is 2-3 clk.
REQ-013 The state machine SHALL have three states: IDLE, GATE, DONE.
REQ-014 IDLE: while en=1, the next clk SHALL enter GATE with gate_cnt=0 and edge_cnt=0; while en=0, the block SHALL stay in IDLE.
REQ-015 GATE: gate_cnt SHALL increment every clk, and edge_cnt SHALL increment on each strobe.
REQ-016 GATE SHALL end on the cycle gate_cnt==GATE_CYC-1, moving to DONE; a strobe on that cycle SHALL be counted.
REQ-017 A gate SHALL therefore span exactly GATE_CYC clk cycles.
REQ-018 edge_cnt SHALL saturate at 2^CNT_W-1; a strobe arriving while saturated SHALL set the internal ovf_flag.
REQ-019 ovf_flag SHALL be cleared on entry to GATE.
REQ-020 DONE SHALL last exactly one clk, during which freq<=edge_cnt, ovf<=ovf_flag and freq_vld=1.
REQ-021 From DONE, the next state SHALL be GATE with counters cleared if en=1, else IDLE.
REQ-022 Strobes occurring in the DONE cycle SHALL be discarded (1-clk dead time per measurement).
REQ-023 Back-to-back measurements SHALL repeat every GATE_CYC+1 clk.
REQ-024 en=0 during GATE SHALL abort to IDLE on the next clk: no freq_vld, and freq/ovf SHALL keep their previous values.
REQ-025 freq_vld SHALL never be high for two consecutive cycles.
REQ-026 busy SHALL be registered and equal (state==GATE).
REQ-027 The measurable range SHALL be defined as edges no closer than 2 clk (sig_in <= clk/2, with high and low each >= 1 clk); behaviour above that range is undefined but SHALL NOT hang the FSM.

Reset
REQ-028 While rst_n=0, the block SHALL force state=IDLE, all counters=0, sync/delay flops=0, freq=0, freq_vld=0, ovf=0, busy=0, effective immediately.
REQ-029 Reset mid-GATE SHALL discard the partial count.
REQ-030 After release with en=1, the block SHALL start a full new gate; the first strobe can occur no earlier than 3 clk after release.

Verification (bench uses GATE_CYC=1000 unless stated)
REQ-031 Scenario: en=1, sig_in period 10 clk (5 high/5 low) -> after 1001 clk, freq=100, freq_vld 1-clk pulse, ovf=0; repeats every 1001 clk.
REQ-032 Scenario: sig_in held 0, then held 1 across a gate -> freq=0, ovf=0 (no edge counted from the constant level).
REQ-033 Scenario: after freq=100, drop en at gate cycle 500 -> busy=0 next clk, no freq_vld, freq stays 100; re-raise en -> new gate, freq=100 again.
REQ-034 Scenario: CNT_W=4, sig_in period 4 clk -> freq=15, ovf=1; next gate with sig_in period 100 clk -> freq=10, ovf=0.
REQ-035 Scenario: sig_in period 2 clk (1 high/1 low) -> freq=500 (or 499 depending on phase); confirm freq is within +/-1 edge.
REQ-036 Scenario: rst_n pulsed low mid-gate -> freq, freq_vld, ovf and busy are 0 asynchronously; after release with en=1 and sig_in period 10 clk, the first freq_vld occurs 1001 clk later with freq=100 (+/-1).
